ray_dispatch: RTL and testbench

Front end of the ray pipeline and the transmitter for the `init` block's request stream. It accepts untagged 256-bit ray records from the host side, allocates a free ray ID (RID) for each, and drives `init_req_stream` with `{ray, rid}`. RIDs come back on a retire port when downstream traversal completes, so at most 2^RID_W rays are in flight at once.

---
 rtl/ray_dispatch_pkg.sv | 14 +
 rtl/ray_dispatch_rid_fifo.sv | 63 ++++++
 rtl/ray_dispatch.sv | 134 +++++++++++++
 tb/tb_ray_dispatch.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_dispatch_pkg.sv
// Shared constants for the ray dispatch front end.
//   RID_WIDTH  : default ray-ID width (N_RID = 2**RID_WIDTH IDs in flight)
//   RAY_WIDTH  : ray record width, eight 32-bit words
//   init_req_width() : width of the {ray, rid} request word sent to init
package ray_dispatch_pkg;

    localparam int RID_WIDTH = 2;
    localparam int RAY_WIDTH = 256;

    function automatic int init_req_width(input int ray_w, input int rid_w);
        return ray_w + rid_w;
    endfunction

endpackage

// File: rtl/ray_dispatch_rid_fifo.sv
// rid_fifo: small synchronous FIFO holding retired ray IDs for reuse.
// The head entry is visible combinationally so an ID can be allocated in
// the same cycle it is popped.
//   clk, arst       : clock, asynchronous active-high reset (pointers only)
//   push, push_dat  : write one ID
//   pop             : consume the head entry (ignored when empty)
//   head            : current head entry
//   empty, count    : occupancy status
module rid_fifo
    import ray_dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = RID_WIDTH
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (count_reg < (AW+1)'(DEPTH));

    // Storage is not reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/ray_dispatch.sv
// ray_dispatch: tags incoming ray records with a free ray ID and forwards
// {ray, rid} to the init block. IDs are handed out fresh (0..N_RID-1) until
// exhausted, then recycled from retired IDs in retire order.
//   ray_in_*                 : untagged ray records (valid/ready)
//   init_req_stream_rsc_*    : tagged requests, rid in the LSBs (valid/ready)
//   rid_ret_*                : retired IDs, always accepted
//   inflight                 : allocated, unretired IDs
//   idle                     : nothing in flight and no request pending
//   err                      : sticky, a retire named an ID that was not out
module ray_dispatch
    import ray_dispatch_pkg::*;
#(
    parameter int RID_W = RID_WIDTH,
    parameter int RAY_W = RAY_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   arst,
    input  logic [RAY_W-1:0]                       ray_in_dat,
    input  logic                                   ray_in_vld,
    output logic                                   ray_in_rdy,
    output logic [init_req_width(RAY_W,RID_W)-1:0] init_req_stream_rsc_dat,
    output logic                                   init_req_stream_rsc_vld,
    input  logic                                   init_req_stream_rsc_rdy,
    input  logic [RID_W-1:0]                       rid_ret_dat,
    input  logic                                   rid_ret_vld,
    output logic                                   rid_ret_rdy,
    output logic [RID_W:0]                         inflight,
    output logic                                   idle,
    output logic                                   err
);

    localparam int N_RID = 2 ** RID_W;
    localparam int REQ_W = init_req_width(RAY_W, RID_W);

    logic [RID_W:0]   fresh_reg;
    logic [N_RID-1:0] outstanding_reg;
    logic [N_RID-1:0] outstanding_next;
    logic [REQ_W-1:0] out_dat_reg;
    logic             out_vld_reg;
    logic [RID_W:0]   inflight_reg;
    logic             err_reg;

    logic             fresh_avail;
    logic             fifo_empty;
    logic [RID_W-1:0] fifo_head;
    logic [RID_W:0]   fifo_count;
    logic             id_avail;
    logic [RID_W-1:0] alloc_rid;
    logic             accept;
    logic             ret_ok;
    logic             ret_bad;

    // Fresh counter stops at N_RID, so its MSB alone marks exhaustion.
    assign fresh_avail = ~fresh_reg[RID_W];
    assign id_avail    = fresh_avail | ~fifo_empty;
    assign alloc_rid   = fresh_avail ? fresh_reg[RID_W-1:0] : fifo_head;

    // Ready is forced low while reset is asserted so nothing is taken then.
    assign ray_in_rdy  = ~arst & id_avail & (~out_vld_reg | init_req_stream_rsc_rdy);
    assign accept      = ray_in_vld & ray_in_rdy;

    assign ret_ok      = rid_ret_vld &  outstanding_reg[rid_ret_dat];
    assign ret_bad     = rid_ret_vld & ~outstanding_reg[rid_ret_dat];

    assign rid_ret_rdy             = 1'b1;
    assign init_req_stream_rsc_dat = out_dat_reg;
    assign init_req_stream_rsc_vld = out_vld_reg;
    assign inflight                = inflight_reg;
    assign idle                    = (inflight_reg == '0) & ~out_vld_reg;
    assign err                     = err_reg;

    // A retired ID is pushed here and only becomes allocatable next cycle,
    // since the head is taken from registered FIFO state.
    rid_fifo #(
        .DEPTH (N_RID),
        .W     (RID_W)
    ) u_fifo (
        .clk      (clk),
        .arst     (arst),
        .push     (ret_ok),
        .push_dat (rid_ret_dat),
        .pop      (accept & ~fresh_avail),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Accepted and retired IDs are always distinct: one is free, the other
    // is outstanding, so clear-then-set never collides.
    always_comb begin
        outstanding_next = outstanding_reg;
        if (ret_ok) begin
            outstanding_next[rid_ret_dat] = 1'b0;
        end
        if (accept) begin
            outstanding_next[alloc_rid] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            fresh_reg       <= '0;
            outstanding_reg <= '0;
            out_dat_reg     <= '0;
            out_vld_reg     <= 1'b0;
            inflight_reg    <= '0;
            err_reg         <= 1'b0;
        end else begin
            outstanding_reg <= outstanding_next;
            if (accept) begin
                out_dat_reg <= {ray_in_dat, alloc_rid};
                out_vld_reg <= 1'b1;
                if (fresh_avail) begin
                    fresh_reg <= fresh_reg + 1'b1;
                end
            end else if (init_req_stream_rsc_rdy) begin
                out_vld_reg <= 1'b0;
            end
            case ({accept, ret_ok})
                2'b10:   inflight_reg <= inflight_reg + 1'b1;
                2'b01:   inflight_reg <= inflight_reg - 1'b1;
                default: inflight_reg <= inflight_reg;
            endcase
            if (ret_bad) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Every push corresponds to an outstanding ID, so the FIFO cannot fill.
    a_no_overflow: assert property (@(posedge clk) disable iff (arst)
        ret_ok |-> (fifo_count < (RID_W+1)'(N_RID)));

endmodule

// File: tb/tb_ray_dispatch.sv
module tb_ray_dispatch;
    import ray_dispatch_pkg::*;

    localparam int RID_W = RID_WIDTH;
    localparam int RAY_W = RAY_WIDTH;
    localparam int N_RID = 2 ** RID_W;
    localparam int REQ_W = RAY_W + RID_W;

    logic             clk;
    logic             arst;
    logic [RAY_W-1:0] ray_in_dat;
    logic             ray_in_vld;
    logic             ray_in_rdy;
    logic [REQ_W-1:0] req_dat;
    logic             req_vld;
    logic             req_rdy;
    logic [RID_W-1:0] rid_ret_dat;
    logic             rid_ret_vld;
    logic             rid_ret_rdy;
    logic [RID_W:0]   inflight;
    logic             idle;
    logic             err;

    int checks = 0;
    int errors = 0;
    int xfer_count = 0;

    ray_dispatch #(.RID_W(RID_W), .RAY_W(RAY_W)) dut (
        .clk                     (clk),
        .arst                    (arst),
        .ray_in_dat              (ray_in_dat),
        .ray_in_vld              (ray_in_vld),
        .ray_in_rdy              (ray_in_rdy),
        .init_req_stream_rsc_dat (req_dat),
        .init_req_stream_rsc_vld (req_vld),
        .init_req_stream_rsc_rdy (req_rdy),
        .rid_ret_dat             (rid_ret_dat),
        .rid_ret_vld             (rid_ret_vld),
        .rid_ret_rdy             (rid_ret_rdy),
        .inflight                (inflight),
        .idle                    (idle),
        .err                     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One line per completed init request transfer.
    always @(posedge clk) begin
        if (!arst && req_vld && req_rdy) begin
            xfer_count <= xfer_count + 1;
            $display("XFER rid=%0d ray_w0=%08h", req_dat[RID_W-1:0], req_dat[RID_W +: 32]);
        end
    end

    function automatic logic [RAY_W-1:0] make_ray(input int k);
        logic [RAY_W-1:0] r;
        for (int j = 0; j < RAY_W / 32; j++) begin
            r[j*32 +: 32] = 32'(k) * 32'h9E37_79B9 + 32'(j * 16 + 1);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1;
        ray_in_vld = 1'b0;
        rid_ret_vld = 1'b0;
        rid_ret_dat = '0;
        req_rdy = 1'b1;
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (req_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %0b want 0", req_vld); end
        checks++; if (req_dat !== '0) begin errors++; $display("FAIL reset_dat got %0h want 0", req_dat); end
        checks++; if (ray_in_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %0b want 0", ray_in_rdy); end
        checks++; if (inflight !== '0) begin errors++; $display("FAIL reset_inflight got %0d want 0", inflight); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %0b want 1", idle); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err); end
        checks++; if (rid_ret_rdy !== 1'b1) begin errors++; $display("FAIL ret_rdy got %0b want 1", rid_ret_rdy); end
        arst = 1'b0;
        #1;
        checks++; if (ray_in_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_rdy got %0b want 1", ray_in_rdy); end
        $display("reset: released");
    endtask

    task automatic test_streaming();
        logic [REQ_W-1:0] exp;
        @(negedge clk);
        req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ray_in_vld = 1'b1;
            ray_in_dat = make_ray(i);
            #1;
            checks++; if (ray_in_rdy !== 1'b1) begin errors++; $display("FAIL stream_rdy%0d got %0b want 1", i, ray_in_rdy); end
            tick();
            exp = {make_ray(i), RID_W'(i)};
            checks++; if (req_vld !== 1'b1) begin errors++; $display("FAIL stream_vld%0d got %0b want 1", i, req_vld); end
            checks++; if (req_dat !== exp) begin errors++; $display("FAIL stream_dat%0d got rid %0d w0 %08h want rid %0d w0 %08h", i, req_dat[RID_W-1:0], req_dat[RID_W +: 32], i, exp[RID_W +: 32]); end
            checks++; if (inflight !== (RID_W+1)'(i + 1)) begin errors++; $display("FAIL stream_inflight%0d got %0d want %0d", i, inflight, i + 1); end
            $display("stream: ray %0d issued rid %0d", i, req_dat[RID_W-1:0]);
        end
        ray_in_vld = 1'b0;
        tick();
        checks++; if (req_vld !== 1'b0) begin errors++; $display("FAIL stream_drain_vld got %0b want 0", req_vld); end
        checks++; if (ray_in_rdy !== 1'b0) begin errors++; $display("FAIL exhausted_rdy got %0b want 0", ray_in_rdy); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL stream_idle got %0b want 0", idle); end
    endtask

    task automatic test_exhaustion();
        logic [REQ_W-1:0] exp;
        logic [RID_W-1:0] want [2];
        want[0] = RID_W'(0);
        want[1] = RID_W'(3);
        ray_in_vld = 1'b1;
        ray_in_dat = make_ray(4);
        #1;
        checks++; if (ray_in_rdy !== 1'b0) begin errors++; $display("FAIL exh_wait_rdy got %0b want 0", ray_in_rdy); end
        tick();
        checks++; if (req_vld !== 1'b0) begin errors++; $display("FAIL exh_wait_vld got %0b want 0", req_vld); end
        rid_ret_vld = 1'b1;
        rid_ret_dat = RID_W'(2);
        #1;
        checks++; if (ray_in_rdy !== 1'b0) begin errors++; $display("FAIL exh_bypass_rdy got %0b want 0", ray_in_rdy); end
        tick();
        rid_ret_vld = 1'b0;
        #1;
        checks++; if (ray_in_rdy !== 1'b1) begin errors++; $display("FAIL exh_recycle_rdy got %0b want 1", ray_in_rdy); end
        checks++; if (inflight !== (RID_W+1)'(3)) begin errors++; $display("FAIL exh_inflight3 got %0d want 3", inflight); end
        $display("exhaustion: retired rid 2");
        tick();
        exp = {make_ray(4), RID_W'(2)};
        checks++; if (req_dat !== exp || req_vld !== 1'b1) begin errors++; $display("FAIL exh_rid2 got vld %0b rid %0d want vld 1 rid 2", req_vld, req_dat[RID_W-1:0]); end
        checks++; if (inflight !== (RID_W+1)'(4)) begin errors++; $display("FAIL exh_inflight4 got %0d want 4", inflight); end
        ray_in_vld = 1'b0;
        rid_ret_vld = 1'b1;
        rid_ret_dat = RID_W'(0);
        tick();
        rid_ret_dat = RID_W'(3);
        tick();
        rid_ret_vld = 1'b0;
        checks++; if (inflight !== (RID_W+1)'(2)) begin errors++; $display("FAIL exh_inflight2 got %0d want 2", inflight); end
        $display("exhaustion: retired rid 0 then 3");
        for (int i = 0; i < 2; i++) begin
            ray_in_vld = 1'b1;
            ray_in_dat = make_ray(5 + i);
            tick();
            exp = {make_ray(5 + i), want[i]};
            checks++; if (req_dat !== exp) begin errors++; $display("FAIL recycle_order%0d got rid %0d want rid %0d", i, req_dat[RID_W-1:0], want[i]); end
            $display("exhaustion: ray %0d issued rid %0d", 5 + i, req_dat[RID_W-1:0]);
        end
        ray_in_vld = 1'b0;
        checks++; if (inflight !== (RID_W+1)'(4)) begin errors++; $display("FAIL recycle_inflight got %0d want 4", inflight); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [REQ_W-1:0] exp_a;
        logic [REQ_W-1:0] exp_b;
        int x0;
        do_reset();
        exp_a = {make_ray(10), RID_W'(0)};
        exp_b = {make_ray(11), RID_W'(1)};
        req_rdy = 1'b0;
        ray_in_vld = 1'b1;
        ray_in_dat = make_ray(10);
        #1;
        checks++; if (ray_in_rdy !== 1'b1) begin errors++; $display("FAIL bp_first_rdy got %0b want 1", ray_in_rdy); end
        tick();
        ray_in_dat = make_ray(11);
        x0 = xfer_count;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (ray_in_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy%0d got %0b want 0", c, ray_in_rdy); end
            checks++; if (req_vld !== 1'b1 || req_dat !== exp_a) begin errors++; $display("FAIL bp_hold%0d got vld %0b rid %0d want vld 1 rid 0", c, req_vld, req_dat[RID_W-1:0]); end
            tick();
        end
        req_rdy = 1'b1;
        #1;
        checks++; if (ray_in_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got %0b want 1", ray_in_rdy); end
        tick();
        checks++; if (xfer_count !== x0 + 1) begin errors++; $display("FAIL bp_one_xfer got %0d want %0d", xfer_count - x0, 1); end
        checks++; if (req_dat !== exp_b || req_vld !== 1'b1) begin errors++; $display("FAIL bp_next got vld %0b rid %0d want vld 1 rid 1", req_vld, req_dat[RID_W-1:0]); end
        ray_in_vld = 1'b0;
        tick();
        checks++; if (req_vld !== 1'b0) begin errors++; $display("FAIL bp_clear got %0b want 0", req_vld); end
        checks++; if (xfer_count !== x0 + 2) begin errors++; $display("FAIL bp_xfers got %0d want 2", xfer_count - x0); end
        checks++; if (inflight !== (RID_W+1)'(2)) begin errors++; $display("FAIL bp_inflight got %0d want 2", inflight); end
        $display("backpressure: released after 5 stalled cycles");
    endtask

    task automatic test_illegal_retire();
        do_reset();
        rid_ret_vld = 1'b1;
        rid_ret_dat = RID_W'(1);
        tick();
        rid_ret_vld = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got %0b want 1", err); end
        checks++; if (inflight !== '0) begin errors++; $display("FAIL illegal_inflight got %0d want 0", inflight); end
        $display("illegal: retired unallocated rid 1");
        ray_in_vld = 1'b1;
        ray_in_dat = make_ray(20);
        tick();
        ray_in_vld = 1'b0;
        checks++; if (req_dat[RID_W-1:0] !== RID_W'(0) || inflight !== (RID_W+1)'(1)) begin errors++; $display("FAIL illegal_alloc got rid %0d inflight %0d want rid 0 inflight 1", req_dat[RID_W-1:0], inflight); end
        tick();
        rid_ret_vld = 1'b1;
        rid_ret_dat = RID_W'(0);
        tick();
        checks++; if (inflight !== '0) begin errors++; $display("FAIL legal_ret_inflight got %0d want 0", inflight); end
        checks++; if (dut.u_fifo.count !== (RID_W+1)'(1)) begin errors++; $display("FAIL legal_ret_count got %0d want 1", dut.u_fifo.count); end
        $display("illegal: retired rid 0 (legal)");
        tick();
        rid_ret_vld = 1'b0;
        checks++; if (inflight !== '0) begin errors++; $display("FAIL dup_inflight got %0d want 0", inflight); end
        checks++; if (dut.u_fifo.count !== (RID_W+1)'(1)) begin errors++; $display("FAIL dup_count got %0d want 1", dut.u_fifo.count); end
        $display("illegal: duplicate retire of rid 0");
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b want 1", err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ray_in_vld = 1'b1;
        ray_in_dat = make_ray(30);
        tick();
        checks++; if (req_vld !== 1'b1) begin errors++; $display("FAIL mid_prestate got %0b want 1", req_vld); end
        #3;
        arst = 1'b1;
        #1;
        checks++; if (req_vld !== 1'b0 || req_dat !== '0) begin errors++; $display("FAIL mid_out got vld %0b dat %0h want 0 0", req_vld, req_dat); end
        checks++; if (ray_in_rdy !== 1'b0) begin errors++; $display("FAIL mid_rdy got %0b want 0", ray_in_rdy); end
        checks++; if (inflight !== '0 || idle !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL mid_status got inflight %0d idle %0b err %0b want 0 1 0", inflight, idle, err); end
        ray_in_vld = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        #1;
        checks++; if (ray_in_rdy !== 1'b1) begin errors++; $display("FAIL mid_release_rdy got %0b want 1", ray_in_rdy); end
        rid_ret_vld = 1'b1;
        rid_ret_dat = RID_W'(0);
        tick();
        rid_ret_vld = 1'b0;
        checks++; if (err !== 1'b1 || inflight !== '0) begin errors++; $display("FAIL forgotten_rid got err %0b inflight %0d want 1 0", err, inflight); end
        $display("reset_mid: forgotten rid 0 retired");
    endtask

    task automatic test_random();
        localparam int NRAYS = 300;
        logic [RAY_W-1:0] exp_q [$];
        logic [N_RID-1:0] busy;
        logic [RAY_W-1:0] exp_ray;
        logic [RID_W-1:0] rid;
        int cand [$];
        int model_inflight;
        int sent;
        int recvd;
        int cycles;
        do_reset();
        busy = '0;
        model_inflight = 0;
        sent = 0;
        recvd = 0;
        cycles = 0;
        while (recvd < NRAYS && cycles < 20000) begin
            checks++; if (inflight !== (RID_W+1)'(model_inflight)) begin errors++; $display("FAIL rnd_inflight cycle %0d got %0d want %0d", cycles, inflight, model_inflight); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL rnd_err cycle %0d got %0b want 0", cycles, err); end
            ray_in_vld = (sent < NRAYS) && ($urandom_range(0, 3) != 0);
            ray_in_dat = make_ray(1000 + sent);
            req_rdy = ($urandom_range(0, 3) != 0);
            cand.delete();
            for (int r = 0; r < N_RID; r++) begin
                if (busy[r]) cand.push_back(r);
            end
            rid_ret_vld = 1'b0;
            if (cand.size() > 0 && $urandom_range(0, 1) == 0) begin
                rid = RID_W'(cand[$urandom_range(0, cand.size() - 1)]);
                rid_ret_vld = 1'b1;
                rid_ret_dat = rid;
                busy[rid] = 1'b0;
                model_inflight--;
            end
            #1;
            if (req_vld && req_rdy) begin
                rid = req_dat[RID_W-1:0];
                checks++; if (busy[rid] !== 1'b0) begin errors++; $display("FAIL rnd_dup_rid got rid %0d already outstanding", rid); end
                busy[rid] = 1'b1;
                exp_ray = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                checks++; if (req_dat[REQ_W-1:RID_W] !== exp_ray) begin errors++; $display("FAIL rnd_ray %0d got w0 %08h want w0 %08h", recvd, req_dat[RID_W +: 32], exp_ray[31:0]); end
                recvd++;
            end
            if (ray_in_vld && ray_in_rdy) begin
                exp_q.push_back(ray_in_dat);
                sent++;
                model_inflight++;
            end
            checks++; if (model_inflight > N_RID) begin errors++; $display("FAIL rnd_bound got %0d want <= %0d", model_inflight, N_RID); end
            tick();
            cycles++;
        end
        ray_in_vld = 1'b0;
        rid_ret_vld = 1'b0;
        req_rdy = 1'b1;
        checks++; if (recvd != NRAYS) begin errors++; $display("FAIL rnd_timeout got %0d rays want %0d", recvd, NRAYS); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_leftover got %0d want 0", exp_q.size()); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rnd_err_end got %0b want 0", err); end
        $display("random: %0d rays in %0d cycles", recvd, cycles);
    endtask

    initial begin
        arst = 1'b1;
        ray_in_dat = '0;
        ray_in_vld = 1'b0;
        req_rdy = 1'b1;
        rid_ret_dat = '0;
        rid_ret_vld = 1'b0;
        test_reset();
        test_streaming();
        test_exhaustion();
        test_backpressure();
        test_illegal_retire();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
